// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAULT     = 3'd4
    } pll_state_e;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    // Timer is sized for the longest of the three cycle parameters.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Generic single-bit two-flop synchronizer; output is 0 while in reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, qualifies its locked flag and retries acquisition
// a bounded number of times before reporting a fault.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 64,
    parameter int LOCK_TIMEOUT    = 131072,
    parameter int SETTLE_CYCLES   = 1024,
    parameter int MAX_RETRIES     = 3
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               locked_i,
    input  logic               relock_req,
    output logic               pll_rst,
    output logic               clk_ok,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt,
    output logic [2:0]         state
);

    localparam int TW = timer_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam logic [TW-1:0]      HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0]      TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]      SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    pll_state_e         state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               fail;
    logic               locked_s;

    sync_2ff u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d_i   (locked_i),
        .q_o   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            timer_q <= '0;
            retry_q <= '0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        retry_inc = retry_q + RETRY_W'(1);
        fail      = 1'b0;
        if (relock_req) begin
            state_d = ST_HOLD;
            timer_d = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_HOLD: begin
                    if (timer_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_SETTLE;
                        timer_d = '0;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        fail = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (!locked_s) begin
                        fail = 1'b1;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = ST_LOCKED;
                        timer_d = '0;
                        retry_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!locked_s) begin
                        state_d = ST_HOLD;
                        timer_d = '0;
                        if (loss_q != '1) loss_d = loss_q + LOSS_W'(1);
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end
            endcase
            // Timeout and settle drop share one failure path.
            if (fail) begin
                retry_d = retry_inc;
                timer_d = '0;
                state_d = (retry_inc == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
            end
        end
    end

    assign pll_rst       = (state_q == ST_HOLD) || (state_q == ST_FAULT);
    assign clk_ok        = (state_q == ST_LOCKED);
    assign fault         = (state_q == ST_FAULT);
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;
    assign state         = state_q;

endmodule
